// File: rtl/attrib_block_seq.sv
// Attribute-prefixed block sequencer: decodes an attribute word, optionally latches a
// shared word, then forwards L body words through a one-deep output register.
package pkg_en;
  localparam int WIDTH_DATA             = 32;
  localparam int WIDTH_LENGTH           = 8;
  localparam int POSIT_ATTRIB_MODE      = 0;
  localparam int POSIT_ATTRIB_INCOND    = 2;
  localparam int POSIT_ATTRIB_MYATTRIB  = 3;
  localparam int POSIT_ATTRIB_NONZERO   = 4;
  localparam int POSIT_ATTRIB_PULL      = 5;
  localparam int POSIT_ATTRIB_SHARED    = 6;
  localparam int POSIT_ATTRIB_TERM      = 7;
  localparam int POSIT_ATTRIB_LENGTH    = 8;
endpackage

module attrib_block_seq #(
  parameter int WIDTH_DATA   = pkg_en::WIDTH_DATA,
  parameter int WIDTH_LENGTH = pkg_en::WIDTH_LENGTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Valid,
  input  logic [WIDTH_DATA-1:0] I_Data,
  output logic                  O_Nack,
  output logic                  O_Valid,
  output logic [WIDTH_DATA-1:0] O_Data,
  output logic                  O_Last,
  input  logic                  I_Nack,
  output logic [1:0]            O_Mode,
  output logic [3:0]            O_Flags,
  output logic [WIDTH_DATA-1:0] O_Shared,
  output logic                  O_Shared_Valid,
  output logic                  O_Done,
  input  logic                  I_Done_Ack,
  output logic                  O_Busy
);
  typedef enum logic [1:0] {IDLE, SHARED, BODY, DONE} state_t;

  state_t                  state;
  logic [WIDTH_LENGTH-1:0] rem;
  logic                    term;
  logic                    accept;
  logic [WIDTH_LENGTH-1:0] len;
  logic                    attr_shared;
  logic                    attr_term;

  assign len         = I_Data[pkg_en::POSIT_ATTRIB_LENGTH +: WIDTH_LENGTH];
  assign attr_shared = I_Data[pkg_en::POSIT_ATTRIB_SHARED];
  assign attr_term   = I_Data[pkg_en::POSIT_ATTRIB_TERM];

  // Body words stall only while the output register is full and blocked downstream.
  assign O_Nack = (state == DONE) || ((state == BODY) && O_Valid && I_Nack);
  assign O_Done = (state == DONE);
  assign O_Busy = (state != IDLE);
  assign accept = I_Valid && !O_Nack;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      rem            <= '0;
      term           <= 1'b0;
      O_Valid        <= 1'b0;
      O_Last         <= 1'b0;
      O_Data         <= '0;
      O_Mode         <= 2'd0;
      O_Flags        <= 4'd0;
      O_Shared       <= '0;
      O_Shared_Valid <= 1'b0;
    end else begin
      // A taken word leaves the register; a body accept below refills it in the same cycle.
      if (O_Valid && !I_Nack) begin
        O_Valid <= 1'b0;
        O_Last  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            O_Mode         <= I_Data[pkg_en::POSIT_ATTRIB_MODE +: 2];
            O_Flags        <= {I_Data[pkg_en::POSIT_ATTRIB_PULL],
                               I_Data[pkg_en::POSIT_ATTRIB_NONZERO],
                               I_Data[pkg_en::POSIT_ATTRIB_MYATTRIB],
                               I_Data[pkg_en::POSIT_ATTRIB_INCOND]};
            O_Shared_Valid <= 1'b0;
            term           <= attr_term;
            rem            <= len;
            if (attr_shared)    state <= SHARED;
            else if (len != '0) state <= BODY;
            else if (attr_term) state <= DONE;
            else                state <= IDLE;
          end
        end
        SHARED: begin
          if (accept) begin
            O_Shared       <= I_Data;
            O_Shared_Valid <= 1'b1;
            if (rem != '0)  state <= BODY;
            else if (term)  state <= DONE;
            else            state <= IDLE;
          end
        end
        BODY: begin
          if (accept) begin
            O_Data  <= I_Data;
            O_Valid <= 1'b1;
            O_Last  <= (rem == WIDTH_LENGTH'(1));
            if (rem != '0) rem <= rem - WIDTH_LENGTH'(1);
            if (rem <= WIDTH_LENGTH'(1)) state <= term ? DONE : IDLE;
          end
        end
        DONE: begin
          if (I_Done_Ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
